// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: datapath width, instruction
// register select encodings, NOP encoding and fetch state encodings.
package fetch_ctrl_pkg;

    // Datapath / address width
    localparam int unsigned REG_LEN = 32;

    // Select encodings for the instruction register (shared with that block)
    localparam logic [1:0] INST_OLD = 2'b00;
    localparam logic [1:0] INST_NOP = 2'b01;
    localparam logic [1:0] INST_MEM = 2'b10;

    // Encoding of the bubble instruction loaded when INST_NOP is selected
    localparam logic [REG_LEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Word-alignment mask for fetch addresses
    localparam logic [REG_LEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FS_BOOT = 2'b00,   // nothing in the memory cycle yet
        FS_RUN  = 2'b01,   // streaming sequential fetches
        FS_HOLD = 2'b10    // stalled with a valid word in the memory cycle
    } fetch_state_t;

    // Force an address onto a word boundary
    function automatic logic [REG_LEN-1:0] align_addr(input logic [REG_LEN-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_ctrl_perf_cnt.sv
// Saturating bubble/stall counter pair for the fetch sequencer.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt
    import fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble_inc,
    input  logic        stall_inc,
    output logic [31:0] bubble_cnt,
    output logic [31:0] stall_cnt
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] bubble_cnt_r;
    logic [31:0] stall_cnt_r;

    // Count bubble and stall cycles, clearing on reset and sticking at the maximum
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_r <= 32'h0000_0000;
            stall_cnt_r  <= 32'h0000_0000;
        end else begin
            if (bubble_inc && (bubble_cnt_r != CNT_MAX)) begin
                bubble_cnt_r <= bubble_cnt_r + 32'h0000_0001;
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
            if (stall_inc && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_r;
    assign stall_cnt  = stall_cnt_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer feeding the instruction register.
// Drives the synchronous instruction memory address, selects OLD/NOP/MEM for
// the instruction register and tracks the PC of the instruction it holds.
// Optional feature: define FETCH_PERF_CNT_EN to add bubble_cnt/stall_cnt.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [REG_LEN-1:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned        PC_STEP    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [REG_LEN-1:0] redirect_addr,
    output logic [REG_LEN-1:0] imem_addr,
    output logic [1:0]         inst_sel,
    output logic [REG_LEN-1:0] pc_out,
`ifdef FETCH_PERF_CNT_EN
    output logic               pc_out_valid,
    output logic [31:0]        bubble_cnt,
    output logic [31:0]        stall_cnt
`else
    output logic               pc_out_valid
`endif
);

    localparam logic [REG_LEN-1:0] STEP = REG_LEN'(PC_STEP);

    fetch_state_t       state_r;
    logic [REG_LEN-1:0] pc_f_r;
    logic [REG_LEN-1:0] pc_m_r;
    logic               m_valid_r;
    logic [REG_LEN-1:0] pc_out_r;
    logic               pc_out_valid_r;

    logic [REG_LEN-1:0] target_s;
    logic [1:0]         inst_sel_s;
    logic [REG_LEN-1:0] imem_addr_s;
    logic               m_valid_s;

    assign target_s = align_addr(redirect_addr);

    // Memory-cycle validity as seen by the outputs; an unknown state is treated as empty
    always_comb begin
        m_valid_s = 1'b0;
        case (state_r)
            FS_BOOT: m_valid_s = 1'b0;
            FS_RUN:  m_valid_s = m_valid_r;
            FS_HOLD: m_valid_s = m_valid_r;
            default: m_valid_s = 1'b0;
        endcase
    end

    // Select the instruction register source and next memory address by priority
    always_comb begin
        inst_sel_s  = INST_NOP;
        imem_addr_s = RESET_ADDR;
        if (rst) begin
            inst_sel_s  = INST_NOP;
            imem_addr_s = RESET_ADDR;
        end else if (redirect_valid) begin
            inst_sel_s  = INST_NOP;
            imem_addr_s = target_s;
        end else if (stall && m_valid_s) begin
            // Re-read the held word so rdata stays valid for the release cycle
            inst_sel_s  = INST_OLD;
            imem_addr_s = pc_m_r;
        end else if (!m_valid_s) begin
            inst_sel_s  = INST_NOP;
            imem_addr_s = pc_f_r;
        end else begin
            inst_sel_s  = INST_MEM;
            imem_addr_s = pc_f_r;
        end
    end

    // Fetch state machine: PC pipeline, memory-cycle tracking and output PC
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_r         <= RESET_ADDR;
            pc_m_r         <= RESET_ADDR;
            m_valid_r      <= 1'b0;
            pc_out_r       <= RESET_ADDR;
            pc_out_valid_r <= 1'b0;
            state_r        <= FS_BOOT;
        end else if (redirect_valid) begin
            // Target enters the memory cycle now; one bubble goes to the register
            pc_m_r         <= target_s;
            m_valid_r      <= 1'b1;
            pc_f_r         <= target_s + STEP;
            pc_out_r       <= pc_out_r;
            pc_out_valid_r <= 1'b0;
            state_r        <= FS_RUN;
        end else if (stall) begin
            pc_f_r         <= pc_f_r;
            pc_m_r         <= pc_m_r;
            m_valid_r      <= m_valid_r;
            pc_out_r       <= pc_out_r;
            pc_out_valid_r <= pc_out_valid_r;
            if (m_valid_s) begin
                state_r <= FS_HOLD;
            end else begin
                state_r <= FS_BOOT;
            end
        end else begin
            pc_m_r         <= pc_f_r;
            m_valid_r      <= 1'b1;
            pc_f_r         <= pc_f_r + STEP;
            pc_out_r       <= pc_m_r;
            pc_out_valid_r <= m_valid_s;
            state_r        <= FS_RUN;
        end
    end

    assign inst_sel     = inst_sel_s;
    assign imem_addr    = imem_addr_s;
    assign pc_out       = pc_out_r;
    assign pc_out_valid = pc_out_valid_r;

`ifdef FETCH_PERF_CNT_EN
    logic bubble_inc_s;
    logic stall_inc_s;

    assign bubble_inc_s = (!rst) && (inst_sel_s == INST_NOP);
    assign stall_inc_s  = (inst_sel_s == INST_OLD);

    fetch_perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .bubble_inc (bubble_inc_s),
        .stall_inc  (stall_inc_s),
        .bubble_cnt (bubble_cnt),
        .stall_cnt  (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the driver pushes hand-computed expected
// outputs per cycle, a negedge monitor pops and compares them.
// A second instance with RESET_ADDR=FFFFFFF8 exercises address wrap-around.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] addr;
        logic        pc_chk;
        logic [31:0] pc;
        logic        pcv;
        logic        w_chk;
        logic [31:0] w_addr;
        logic [31:0] w_pc;
        logic        cnt_chk;
        logic [31:0] bub;
        logic [31:0] stl;
    } exp_t;

    localparam logic [31:0] WR = 32'hFFFF_FFF8;

    logic        clk = 1'b1;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic [31:0] imem_addr;
    logic [1:0]  inst_sel;
    logic [31:0] pc_out;
    logic        pc_out_valid;

    logic        w_stall = 1'b0;
    logic        w_rv    = 1'b0;
    logic [31:0] w_ra    = 32'h0000_0000;
    logic [31:0] w_imem_addr;
    logic [1:0]  w_inst_sel;
    logic [31:0] w_pc_out;
    logic        w_pc_out_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt, stall_cnt, w_bubble_cnt, w_stall_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_ADDR(32'h0000_0000), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_addr(imem_addr), .inst_sel(inst_sel), .pc_out(pc_out),
`ifdef FETCH_PERF_CNT_EN
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt),
`endif
        .pc_out_valid(pc_out_valid)
    );

    fetch_ctrl #(.RESET_ADDR(WR), .PC_STEP(4)) dut_wrap (
        .clk(clk), .rst(rst), .stall(w_stall),
        .redirect_valid(w_rv), .redirect_addr(w_ra),
        .imem_addr(w_imem_addr), .inst_sel(w_inst_sel), .pc_out(w_pc_out),
`ifdef FETCH_PERF_CNT_EN
        .bubble_cnt(w_bubble_cnt), .stall_cnt(w_stall_cnt),
`endif
        .pc_out_valid(w_pc_out_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, advance past the edge
    task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] ra,
                        input logic [1:0] sel, input logic [31:0] addr,
                        input logic pc_chk, input logic [31:0] pc, input logic pcv,
                        input logic wc = 1'b0, input logic [31:0] wa = 32'h0,
                        input logic [31:0] wp = 32'h0,
                        input logic cc = 1'b0, input logic [31:0] bub = 32'h0,
                        input logic [31:0] stl = 32'h0);
        exp_t e;
        rst = r; stall = s; redirect_valid = rv; redirect_addr = ra;
        e.sel = sel; e.addr = addr; e.pc_chk = pc_chk; e.pc = pc; e.pcv = pcv;
        e.w_chk = wc; e.w_addr = wa; e.w_pc = wp;
        e.cnt_chk = cc; e.bub = bub; e.stl = stl;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop one expectation per cycle and compare at the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("inst_sel", {30'h0, inst_sel}, {30'h0, e.sel});
            chk("imem_addr", imem_addr, e.addr);
            if (e.pc_chk) begin
                chk("pc_out", pc_out, e.pc);
                chk("pc_out_valid", {31'h0, pc_out_valid}, {31'h0, e.pcv});
            end
            if (e.w_chk) begin
                chk("wrap_imem_addr", w_imem_addr, e.w_addr);
                chk("wrap_pc_out", w_pc_out, e.w_pc);
            end
`ifdef FETCH_PERF_CNT_EN
            if (e.cnt_chk) begin
                chk("bubble_cnt", bubble_cnt, e.bub);
                chk("stall_cnt", stall_cnt, e.stl);
            end
`endif
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0;
        // Reset, then sequential fetch from 0
        step(1'b1, 1'b0, 1'b0, 32'h0, INST_NOP, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, INST_NOP, 32'h0, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_NOP, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, WR, WR);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'h4, 1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, WR);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'h8, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0, WR);
        // Stall three cycles with pc_m=8
        step(1'b0, 1'b1, 1'b0, 32'h0, INST_OLD, 32'h8, 1'b1, 32'h4, 1'b1, 1'b1, 32'h4, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'h0, INST_OLD, 32'h8, 1'b1, 32'h4, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, INST_OLD, 32'h8, 1'b1, 32'h4, 1'b1);
        // Release: 8 then 12 appear, nothing skipped or repeated
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'hC, 1'b1, 32'h4, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'h10, 1'b1, 32'h8, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'h14, 1'b1, 32'hC, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'h18, 1'b1, 32'h10, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'h1C, 1'b1, 32'h14, 1'b1);
        // Redirect to 0x100 while fetching 0x20
        step(1'b0, 1'b0, 1'b1, 32'h100, INST_NOP, 32'h100, 1'b1, 32'h18, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'h104, 1'b1, 32'h18, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'h108, 1'b1, 32'h100, 1'b1);
        // Redirect and stall together, unaligned target 0x203
        step(1'b0, 1'b1, 1'b1, 32'h203, INST_NOP, 32'h200, 1'b1, 32'h104, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'h204, 1'b1, 32'h104, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'h208, 1'b1, 32'h200, 1'b1);
        // Stall, then reset pulsed mid-stall
        step(1'b0, 1'b1, 1'b0, 32'h0, INST_OLD, 32'h208, 1'b1, 32'h204, 1'b1,
             1'b0, 32'h0, 32'h0, 1'b1, 32'd3, 32'd3);
        step(1'b1, 1'b1, 1'b0, 32'h0, INST_NOP, 32'h0, 1'b1, 32'h204, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, INST_NOP, 32'h0, 1'b1, 32'h0, 1'b0,
             1'b0, 32'h0, 32'h0, 1'b1, 32'd0, 32'd0);
        // Stall in BOOT keeps the bubble; release resumes from RESET_ADDR
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_NOP, 32'h0, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'h4, 1'b1, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, INST_MEM, 32'h8, 1'b1, 32'h0, 1'b1);
        // Let the monitor drain, bounded
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        chk("queue_drain", q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
